// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: circular capture of retired {pc, instr, rd_wdata}
// beside the CPU writeback stage. It freezes a fixed number of commits after
// a trigger, and the frozen trace is read back by oldest-relative index.
module commit_trace_buffer #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned POST_TRIG = 32,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               clear,
  input  logic               trig,
  input  logic               commit_valid,
  input  logic [PC_W-1:0]    commit_pc,
  input  logic [INSTR_W-1:0] commit_instr,
  input  logic [DATA_W-1:0]  commit_wdata,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_idx,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [DATA_W-1:0]  rd_wdata,
  output logic               rd_valid,
  output logic               rd_err,
  output logic [1:0]         state,
  output logic [AW:0]        count,
  output logic [AW-1:0]      trig_pos,
  output logic               wrapped
);

  localparam int unsigned EW        = PC_W + INSTR_W + DATA_W;
  localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0] POST_LAST = (AW+1)'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);
  localparam bit          NO_POST   = (POST_TRIG == 0);
  localparam bit          ONE_POST  = (POST_TRIG == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_TRIG  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     post_cnt_q;
  logic [AW-1:0]   tptr_q;
  logic [AW-1:0]   trig_pos_q;
  logic            wrapped_q;

  logic            rd_valid_q;
  logic            rd_err_q;
  logic [PC_W-1:0]    rd_pc_q;
  logic [INSTR_W-1:0] rd_instr_q;
  logic [DATA_W-1:0]  rd_wdata_q;

  logic [EW-1:0]   mem [DEPTH];

  logic            capture;
  logic            wr_fire;
  logic [AW:0]     count_d;
  logic [AW-1:0]   trig_pos_d;
  logic [AW-1:0]   rd_phys;

  // Write qualification, saturating count and read-order address arithmetic
  always_comb begin
    capture    = (state_q == S_TRIG) || ((state_q == S_ARMED) && !(trig && NO_POST));
    wr_fire    = commit_valid && capture && !clear && !arm;
    count_d    = (count_q == FULL) ? count_q : count_q + 1'b1;
    // Trigger slot relative to the oldest entry once the current write lands
    trig_pos_d = tptr_q + count_d[AW-1:0] - wr_ptr_q - 1'b1;
    rd_phys    = wr_ptr_q - count_q[AW-1:0] + rd_idx;
  end

  // Trace storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= {commit_pc, commit_instr, commit_wdata};
    end
  end

  // Capture FSM with write pointer, fill count, trigger bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      tptr_q     <= '0;
      trig_pos_q <= '0;
      wrapped_q  <= 1'b0;
    end else if (clear) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      post_cnt_q <= '0;
      wrapped_q  <= 1'b0;
    end else if (arm) begin
      state_q    <= S_ARMED;
      count_q    <= '0;
      post_cnt_q <= '0;
      wrapped_q  <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q  <= count_d;
        if (count_q == FULL) begin
          wrapped_q <= 1'b1;
        end
      end
      case (state_q)
        S_ARMED: begin
          if (trig) begin
            if (NO_POST) begin
              state_q <= S_DONE;
              if (count_q != '0) begin
                trig_pos_q <= AW'(count_q - 1'b1);
              end else begin
                trig_pos_q <= '0;
              end
            end else begin
              // Trigger entry is the slot the same-cycle (or next) commit lands in
              tptr_q     <= wr_ptr_q;
              post_cnt_q <= commit_valid ? (AW+1)'(1) : '0;
              if (ONE_POST && commit_valid) begin
                state_q    <= S_DONE;
                trig_pos_q <= AW'(count_d - 1'b1);
              end else begin
                state_q <= S_TRIG;
              end
            end
          end
        end
        S_TRIG: begin
          if (commit_valid) begin
            post_cnt_q <= post_cnt_q + 1'b1;
            if (post_cnt_q == POST_LAST) begin
              state_q    <= S_DONE;
              trig_pos_q <= trig_pos_d;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered read port; errors return zero data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_pc_q    <= '0;
      rd_instr_q <= '0;
      rd_wdata_q <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        if ((state_q == S_DONE) && ({1'b0, rd_idx} < count_q)) begin
          {rd_pc_q, rd_instr_q, rd_wdata_q} <= mem[rd_phys];
          rd_err_q <= 1'b0;
        end else begin
          rd_pc_q    <= '0;
          rd_instr_q <= '0;
          rd_wdata_q <= '0;
          rd_err_q   <= 1'b1;
        end
      end else begin
        rd_err_q <= 1'b0;
      end
    end
  end

  assign rd_pc    = rd_pc_q;
  assign rd_instr = rd_instr_q;
  assign rd_wdata = rd_wdata_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign state    = state_q;
  assign count    = count_q;
  assign trig_pos = trig_pos_q;
  assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: three configurations share one stimulus
// stream and are compared every cycle against a history-based model.
module tb_commit_trace_buffer;

  logic        clk, rst, arm, clear, trig, cv, rd_en;
  logic [31:0] cpc, cins, cwd;
  logic [5:0]  rd_idx;

  logic [31:0] a_rd_pc, a_rd_instr, a_rd_wdata;
  logic [31:0] b_rd_pc, b_rd_instr, b_rd_wdata;
  logic [31:0] c_rd_pc, c_rd_instr, c_rd_wdata;
  logic        a_rd_valid, a_rd_err, a_wrapped;
  logic        b_rd_valid, b_rd_err, b_wrapped;
  logic        c_rd_valid, c_rd_err, c_wrapped;
  logic [1:0]  a_state, b_state, c_state;
  logic [3:0]  a_count;
  logic [6:0]  b_count;
  logic [4:0]  c_count;
  logic [2:0]  a_trig_pos;
  logic [5:0]  b_trig_pos;
  logic [3:0]  c_trig_pos;

  commit_trace_buffer #(.DEPTH(8), .POST_TRIG(2)) u_a (
    .clk(clk), .rst(rst), .arm(arm), .clear(clear), .trig(trig),
    .commit_valid(cv), .commit_pc(cpc), .commit_instr(cins), .commit_wdata(cwd),
    .rd_en(rd_en), .rd_idx(rd_idx[2:0]),
    .rd_pc(a_rd_pc), .rd_instr(a_rd_instr), .rd_wdata(a_rd_wdata),
    .rd_valid(a_rd_valid), .rd_err(a_rd_err), .state(a_state), .count(a_count),
    .trig_pos(a_trig_pos), .wrapped(a_wrapped));

  commit_trace_buffer #(.DEPTH(64), .POST_TRIG(32)) u_b (
    .clk(clk), .rst(rst), .arm(arm), .clear(clear), .trig(trig),
    .commit_valid(cv), .commit_pc(cpc), .commit_instr(cins), .commit_wdata(cwd),
    .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_pc(b_rd_pc), .rd_instr(b_rd_instr), .rd_wdata(b_rd_wdata),
    .rd_valid(b_rd_valid), .rd_err(b_rd_err), .state(b_state), .count(b_count),
    .trig_pos(b_trig_pos), .wrapped(b_wrapped));

  commit_trace_buffer #(.DEPTH(16), .POST_TRIG(0)) u_c (
    .clk(clk), .rst(rst), .arm(arm), .clear(clear), .trig(trig),
    .commit_valid(cv), .commit_pc(cpc), .commit_instr(cins), .commit_wdata(cwd),
    .rd_en(rd_en), .rd_idx(rd_idx[3:0]),
    .rd_pc(c_rd_pc), .rd_instr(c_rd_instr), .rd_wdata(c_rd_wdata),
    .rd_valid(c_rd_valid), .rd_err(c_rd_err), .state(c_state), .count(c_count),
    .trig_pos(c_trig_pos), .wrapped(c_wrapped));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Model: each instance keeps the full history of writes since arm;
  // the visible buffer is simply the newest min(total, DEPTH) of them.
  localparam int PD [3] = '{8, 64, 16};
  localparam int PT [3] = '{2, 32, 0};

  int           ms   [3] = '{0, 0, 0};
  int           tot  [3] = '{0, 0, 0};
  int           tabs [3] = '{0, 0, 0};
  int           post [3] = '{0, 0, 0};
  bit           ev   [3] = '{0, 0, 0};
  bit           eerr [3] = '{0, 0, 0};
  logic [95:0]  edat [3];
  logic [95:0]  hist [3][512];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin : mdl
      int cnt, idx;
      cnt = (tot[i] < PD[i]) ? tot[i] : PD[i];
      idx = int'(rd_idx) % PD[i];
      if (rst) begin
        ev[i] = 0; eerr[i] = 0; ms[i] = 0; tot[i] = 0; tabs[i] = 0; post[i] = 0;
      end else begin
        ev[i] = rd_en;
        if (rd_en) begin
          if (ms[i] == 3 && idx < cnt) begin
            eerr[i] = 0; edat[i] = hist[i][tot[i] - cnt + idx];
          end else begin
            eerr[i] = 1; edat[i] = '0;
          end
        end else begin
          eerr[i] = 0;
        end
        if (clear) begin
          ms[i] = 0; tot[i] = 0;
        end else if (arm) begin
          ms[i] = 1; tot[i] = 0;
        end else if (ms[i] == 1 && trig) begin
          if (PT[i] == 0) begin
            ms[i] = 3; tabs[i] = tot[i] - 1;
          end else begin
            ms[i] = 2; tabs[i] = tot[i]; post[i] = 0;
            if (cv) begin
              if (tot[i] < 512) hist[i][tot[i]] = {cpc, cins, cwd};
              tot[i]++;
              post[i] = 1;
              if (post[i] == PT[i]) ms[i] = 3;
            end
          end
        end else if (cv && (ms[i] == 1 || ms[i] == 2)) begin
          if (tot[i] < 512) hist[i][tot[i]] = {cpc, cins, cwd};
          tot[i]++;
          if (ms[i] == 2) begin
            post[i]++;
            if (post[i] == PT[i]) ms[i] = 3;
          end
        end
      end
    end
  end

  int act_st [3], act_cnt [3], act_tp [3], act_wr [3], act_rv [3], act_re [3];
  int act_pc [3], act_in [3], act_wd [3];

  always_comb begin
    act_st  = '{int'(a_state),    int'(b_state),    int'(c_state)};
    act_cnt = '{int'(a_count),    int'(b_count),    int'(c_count)};
    act_tp  = '{int'(a_trig_pos), int'(b_trig_pos), int'(c_trig_pos)};
    act_wr  = '{int'(a_wrapped),  int'(b_wrapped),  int'(c_wrapped)};
    act_rv  = '{int'(a_rd_valid), int'(b_rd_valid), int'(c_rd_valid)};
    act_re  = '{int'(a_rd_err),   int'(b_rd_err),   int'(c_rd_err)};
    act_pc  = '{int'(a_rd_pc),    int'(b_rd_pc),    int'(c_rd_pc)};
    act_in  = '{int'(a_rd_instr), int'(b_rd_instr), int'(c_rd_instr)};
    act_wd  = '{int'(a_rd_wdata), int'(b_rd_wdata), int'(c_rd_wdata)};
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin : cmp
      int cnt, tp;
      cnt = (tot[i] < PD[i]) ? tot[i] : PD[i];
      tp  = tabs[i] - (tot[i] - cnt);
      if (tp < 0) tp = 0;
      chk($sformatf("u%0d.state", i),    act_st[i],  ms[i]);
      chk($sformatf("u%0d.count", i),    act_cnt[i], cnt);
      chk($sformatf("u%0d.wrapped", i),  act_wr[i],  (tot[i] > PD[i]) ? 1 : 0);
      chk($sformatf("u%0d.rd_valid", i), act_rv[i],  int'(ev[i]));
      if (ms[i] == 3) chk($sformatf("u%0d.trig_pos", i), act_tp[i], tp);
      if (ev[i]) begin
        chk($sformatf("u%0d.rd_err", i),   act_re[i], int'(eerr[i]));
        chk($sformatf("u%0d.rd_pc", i),    act_pc[i], int'(edat[i][95:64]));
        chk($sformatf("u%0d.rd_instr", i), act_in[i], int'(edat[i][63:32]));
        chk($sformatf("u%0d.rd_wdata", i), act_wd[i], int'(edat[i][31:0]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    arm = 0; clear = 0; trig = 0; cv = 0; rd_en = 0;
  endtask

  task automatic commit(input int k, input bit t);
    cv   = 1;
    trig = t;
    cpc  = 32'h0040_0000 + 32'(4 * k);
    cins = 32'h0000_0013 | (32'(k) << 20);
    cwd  = 32'(k * 7 + 1);
    tick();
  endtask

  task automatic rd(input int idx);
    rd_en  = 1;
    rd_idx = 6'(idx);
    tick();
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 1; arm = 0; clear = 0; trig = 0; cv = 0; rd_en = 0;
    cpc = '0; cins = '0; cwd = '0; rd_idx = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset.state",    int'(b_state),    0);
    chk("reset.count",    int'(b_count),    0);
    chk("reset.trig_pos", int'(b_trig_pos), 0);
    chk("reset.wrapped",  int'(b_wrapped),  0);
    chk("reset.rd_valid", int'(b_rd_valid), 0);

    // T1: POST_TRIG=2 instance, trigger with 5th commit plus one more
    arm = 1; tick();
    for (int k = 0; k < 4; k++) commit(k, 0);
    commit(4, 1);
    commit(5, 0);
    chk("T1.state",    int'(a_state),    3);
    chk("T1.count",    int'(a_count),    6);
    chk("T1.trig_pos", int'(a_trig_pos), 4);
    chk("T1.c_count",  int'(c_count),    4);
    chk("T1.c_trig",   int'(c_trig_pos), 3);
    rd(0);
    chk("T1.rd_valid", int'(a_rd_valid), 1);
    chk("T1.rd_pc",    int'(a_rd_pc),    32'h0040_0000);
    chk("T1.rd_err",   int'(a_rd_err),   0);
    for (int i = 0; i < 8; i++) rd(i);
    // T4: index equal to count in DONE
    rd(6);
    chk("T4.rd_valid", int'(a_rd_valid), 1);
    chk("T4.rd_err",   int'(a_rd_err),   1);
    chk("T4.rd_pc",    int'(a_rd_pc),    0);

    // T3: trig while IDLE is ignored
    clear = 1; tick();
    chk("T3.cleared", int'(b_state), 0);
    trig = 1; tick();
    arm = 1; tick();
    for (int k = 0; k < 3; k++) commit(k, 0);
    chk("T3.state", int'(b_state), 1);
    chk("T3.count", int'(b_count), 3);
    rd(0);
    chk("T4b.rd_valid", int'(b_rd_valid), 1);
    chk("T4b.rd_err",   int'(b_rd_err),   1);

    // T2: re-arm while ARMED, 100 commits, trigger on #100, 40 more
    arm = 1; tick();
    for (int k = 0; k < 100; k++) commit(k, 0);
    commit(100, 1);
    for (int k = 101; k < 141; k++) commit(k, 0);
    chk("T2.state",    int'(b_state),    3);
    chk("T2.count",    int'(b_count),    64);
    chk("T2.wrapped",  int'(b_wrapped),  1);
    chk("T2.trig_pos", int'(b_trig_pos), 32);
    chk("T2.a_trig",   int'(a_trig_pos), 6);
    chk("T2.c_trig",   int'(c_trig_pos), 15);
    chk("T2.c_count",  int'(c_count),    16);
    rd(0);
    chk("T2.rd_oldest", int'(b_rd_pc), 32'h0040_0110);
    rd(32);
    chk("T2.rd_trig",   int'(b_rd_pc), 32'h0040_0190);
    rd(63);
    chk("T2.rd_newest", int'(b_rd_pc), 32'h0040_020C);

    // T6: POST_TRIG=0 drops the trigger commit
    clear = 1; tick();
    arm = 1; tick();
    for (int k = 0; k < 10; k++) commit(k, 0);
    commit(10, 1);
    chk("T6.state",    int'(c_state),    3);
    chk("T6.count",    int'(c_count),    10);
    chk("T6.trig_pos", int'(c_trig_pos), 9);
    rd(9);
    chk("T6.rd_pc",  int'(c_rd_pc),  32'h0040_0024);
    rd(10);
    chk("T6.rd_err", int'(c_rd_err), 1);

    // T5: clear beats arm; reset during TRIGGERED
    arm = 1; clear = 1; tick();
    chk("T5.arm_clear", int'(b_state), 0);
    arm = 1; tick();
    for (int k = 0; k < 70; k++) commit(k, 0);
    commit(70, 1);
    commit(71, 0);
    commit(72, 0);
    chk("T5.trig_state", int'(b_state),   2);
    chk("T5.trig_wrap",  int'(b_wrapped), 1);
    rst = 1; tick(); rst = 0;
    chk("T5.rst_state",   int'(b_state),   0);
    chk("T5.rst_count",   int'(b_count),   0);
    chk("T5.rst_wrapped", int'(b_wrapped), 0);
    commit(0, 0);
    chk("T5.idle_drop", int'(b_count), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
